// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer sizes and the ROB entry packet
package rob_pkg;

  localparam int N               = 3;
  localparam int ROB_SZ          = 32;
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int ROB_IDX_BITS    = $clog2(ROB_SZ);
  localparam int ROB_CNT_BITS    = $clog2(ROB_SZ + 1);
  localparam int PHYS_REG_IDX    = 6;

  typedef struct packed {
    logic [PHYS_REG_IDX-1:0] T_new;
    logic [PHYS_REG_IDX-1:0] T_old;
    logic [4:0]              dest_reg_idx;
    logic                    has_dest;
    logic                    halt;
    logic [31:0]             NPC;
  } ROB_PACKET;

endpackage

// File: rtl/rob.sv
// rtl/rob.sv - circular reorder buffer, N-wide in-order dispatch and retire
module rob
  import rob_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  ROB_PACKET                  rob_inputs [N],
  input  logic [NUM_SCALAR_BITS-1:0] num_dispatching,
  output logic [NUM_SCALAR_BITS-1:0] rob_spots,
  output ROB_PACKET                  rob_outputs [N],
  output logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid,
  input  logic [NUM_SCALAR_BITS-1:0] num_retiring,
  input  logic                       squash,
  output logic [ROB_IDX_BITS-1:0]    rob_tail
);

  ROB_PACKET                  entries [ROB_SZ];
  logic [ROB_IDX_BITS-1:0]    head;
  logic [ROB_IDX_BITS-1:0]    tail;
  logic [ROB_CNT_BITS-1:0]    count;

  // Neighbour requests clamped to what the buffer can actually honour.
  logic [NUM_SCALAR_BITS-1:0] disp_eff;
  logic [NUM_SCALAR_BITS-1:0] ret_eff;
  logic [ROB_IDX_BITS-1:0]    head_after_retire;

  // Pointer advance; the wrap comes from truncation to the index width.
  function automatic logic [ROB_IDX_BITS-1:0] ptr_add(
    input logic [ROB_IDX_BITS-1:0]    ptr,
    input logic [NUM_SCALAR_BITS-1:0] n
  );
    return ptr + ROB_IDX_BITS'(n);
  endfunction

  // Smaller of two counts, narrowed to a per-cycle count (both callers cap at N).
  function automatic logic [NUM_SCALAR_BITS-1:0] min_cnt(
    input logic [ROB_CNT_BITS-1:0] a,
    input logic [ROB_CNT_BITS-1:0] b
  );
    return (a < b) ? a[NUM_SCALAR_BITS-1:0] : b[NUM_SCALAR_BITS-1:0];
  endfunction

  // Space/occupancy reporting and request clamping, from registered state only.
  always_comb begin
    rob_spots         = min_cnt(ROB_CNT_BITS'(N), ROB_CNT_BITS'(ROB_SZ) - count);
    rob_outputs_valid = min_cnt(ROB_CNT_BITS'(N), count);
    disp_eff          = (num_dispatching < rob_spots) ? num_dispatching : rob_spots;
    ret_eff           = (num_retiring < rob_outputs_valid) ? num_retiring : rob_outputs_valid;
    head_after_retire = ptr_add(head, ret_eff);
    rob_tail          = tail;
  end

  // Oldest N entries starting at head, slot 0 oldest.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rob_outputs[i] = entries[ptr_add(head, NUM_SCALAR_BITS'(i))];
    end
  end

  // Pointer and occupancy update; reset beats squash, squash beats dispatch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= head_after_retire;
      tail  <= head_after_retire;
      count <= '0;
    end else begin
      head  <= head_after_retire;
      tail  <= ptr_add(tail, disp_eff);
      count <= count + ROB_CNT_BITS'(disp_eff) - ROB_CNT_BITS'(ret_eff);
    end
  end

  // Entry storage is never cleared; only accepted dispatch slots are written.
  always_ff @(posedge clock) begin
    if (reset && !squash) begin
      for (int i = 0; i < N; i++) begin
        if (NUM_SCALAR_BITS'(i) < disp_eff) begin
          entries[ptr_add(tail, NUM_SCALAR_BITS'(i))] <= rob_inputs[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - self-checking bench for the reorder buffer
module tb_rob;
  import rob_pkg::*;

  logic                       clock;
  logic                       reset;
  ROB_PACKET                  rob_inputs [N];
  logic [NUM_SCALAR_BITS-1:0] num_dispatching;
  logic [NUM_SCALAR_BITS-1:0] rob_spots;
  ROB_PACKET                  rob_outputs [N];
  logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid;
  logic [NUM_SCALAR_BITS-1:0] num_retiring;
  logic                       squash;
  logic [ROB_IDX_BITS-1:0]    rob_tail;

  rob dut (
    .clock             (clock),
    .reset             (reset),
    .rob_inputs        (rob_inputs),
    .num_dispatching   (num_dispatching),
    .rob_spots         (rob_spots),
    .rob_outputs       (rob_outputs),
    .rob_outputs_valid (rob_outputs_valid),
    .num_retiring      (num_retiring),
    .squash            (squash),
    .rob_tail          (rob_tail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int next_id = 1;

  // Reference model: the live instructions in program order, plus pointers.
  ROB_PACKET q[$];
  int m_head = 0;
  int m_tail = 0;

  function automatic ROB_PACKET mk(int id);
    ROB_PACKET p;
    p.T_new        = PHYS_REG_IDX'(id);
    p.T_old        = PHYS_REG_IDX'(id + 17);
    p.dest_reg_idx = 5'(id * 3);
    p.has_dest     = id[0];
    p.halt         = (id % 7) == 0;
    p.NPC          = 32'h1000 + 32'(id * 4);
    return p;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("rob_spots", int'(rob_spots), imin(N, ROB_SZ - q.size()));
      check("rob_outputs_valid", int'(rob_outputs_valid), imin(N, q.size()));
      check("rob_tail", int'(rob_tail), m_tail);
      for (int i = 0; i < imin(N, q.size()); i++) begin
        checks++;
        if (rob_outputs[i] !== q[i]) begin
          errors++;
          $display("FAIL rob_outputs[%0d]: got %h expected %h", i, rob_outputs[i], q[i]);
        end
      end
    end
  end

  // One clock: drive requests, let the DUT take the edge, advance the model.
  task automatic cyc(int d, int r, bit sq = 0, bit rst = 1);
    int v, s, re, de;
    for (int i = 0; i < N; i++) rob_inputs[i] = mk(next_id + i);
    num_dispatching = NUM_SCALAR_BITS'(d);
    num_retiring    = NUM_SCALAR_BITS'(r);
    squash          = sq;
    reset           = rst;
    @(posedge clock);
    if (!rst) begin
      q.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      v  = imin(N, q.size());
      s  = imin(N, ROB_SZ - q.size());
      re = imin(r, v);
      de = imin(d, s);
      for (int i = 0; i < re; i++) void'(q.pop_front());
      m_head = (m_head + re) % ROB_SZ;
      if (sq) begin
        q.delete();
        m_tail = m_head;
      end else begin
        for (int i = 0; i < de; i++) q.push_back(mk(next_id + i));
        m_tail = (m_tail + de) % ROB_SZ;
        next_id += de;
      end
    end
    @(negedge clock);
    num_dispatching = '0;
    num_retiring    = '0;
    squash          = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    num_dispatching = '0;
    num_retiring = '0;
    squash = 1'b0;
    for (int i = 0; i < N; i++) rob_inputs[i] = mk(0);
    @(negedge clock);

    // Reset held two cycles while dispatch is requested.
    cyc(3, 0, 0, 0);
    chk_en = 1;
    cyc(3, 0, 0, 0);
    check("reset spots", int'(rob_spots), 3);
    check("reset valid", int'(rob_outputs_valid), 0);
    check("reset tail", int'(rob_tail), 0);
    cyc(0, 0);
    check("nothing written", int'(rob_outputs_valid), 0);

    // Fill to full, then an overflow attempt.
    next_id = 1;
    repeat (10) cyc(3, 0);
    check("count30 spots", int'(rob_spots), 2);
    cyc(2, 0);
    check("full spots", int'(rob_spots), 0);
    cyc(1, 0);
    check("full tail", int'(rob_tail), 0);
    check("full head T_new", int'(rob_outputs[0].T_new), 1);

    // Five entries 1..5, retire two.
    cyc(0, 0, 0, 0);
    next_id = 1;
    cyc(3, 0);
    cyc(2, 0);
    cyc(0, 2);
    check("retire2 valid", int'(rob_outputs_valid), 3);
    check("retire2 slot0", int'(rob_outputs[0].T_new), 3);
    check("retire2 slot1", int'(rob_outputs[1].T_new), 4);
    check("retire2 slot2", int'(rob_outputs[2].T_new), 5);

    // Walk head to 30 on an empty buffer, then dispatch across the wrap.
    cyc(0, 0, 0, 0);
    next_id = 40;
    cyc(3, 0);
    repeat (9) cyc(3, 3);
    cyc(0, 3);
    check("empty valid", int'(rob_outputs_valid), 0);
    next_id = 7;
    cyc(3, 0);
    check("wrap tail", int'(rob_tail), 1);
    check("wrap slot0", int'(rob_outputs[0].T_new), 7);
    check("wrap slot1", int'(rob_outputs[1].T_new), 8);
    check("wrap slot2", int'(rob_outputs[2].T_new), 9);

    // count 31, then simultaneous dispatch 1 / retire 3.
    repeat (9) cyc(3, 0);
    cyc(1, 0);
    check("count31 spots", int'(rob_spots), 1);
    cyc(1, 3);
    check("count29 spots", int'(rob_spots), 3);
    check("count29 valid", int'(rob_outputs_valid), 3);

    // Drain to 12, then squash with one retiring and dispatch ignored.
    repeat (5) cyc(0, 3);
    cyc(0, 2);
    cyc(3, 1, 1);
    check("squash valid", int'(rob_outputs_valid), 0);
    check("squash spots", int'(rob_spots), 3);
    check("squash tail", int'(rob_tail), 19);
    cyc(0, 2);
    check("post squash empty retire", int'(rob_tail), 19);

    // Mid-fill reset at count 17.
    repeat (5) cyc(3, 0);
    cyc(2, 0);
    cyc(2, 0, 0, 0);
    check("midreset valid", int'(rob_outputs_valid), 0);
    next_id = 50;
    cyc(2, 0);
    check("midreset tail", int'(rob_tail), 2);
    check("midreset slot0", int'(rob_outputs[0].T_new), 50);
    check("midreset slot1", int'(rob_outputs[1].T_new), 51);

    // Mixed traffic with over-asking requests.
    for (int k = 0; k < 40; k++) cyc((k * 5) % 4, (k * 7 + 1) % 4, (k == 23));

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
